// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath:
// instruction fields and ALU flags in, mux selects and write enables out.
interface multicycle_control_if;
  logic [3:0] Cond;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] ALUFlags;
  logic       PCWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic       IRWrite;
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcB;
  logic [1:0] RegSrc;
  logic [1:0] ALUControl;
  logic [1:0] ImmSrc;

  modport master (
    input  Cond, Op, Funct, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, RegSrc, ALUControl, ImmSrc
  );

  modport slave (
    output Cond, Op, Funct, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ResultSrc, ALUSrcB, RegSrc, ALUControl, ImmSrc
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle ARM-subset controller: main FSM, ALU decode, condition check
// with flags and a per-instruction latched condition result.
module multicycle_control (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } ctrlState;

  ctrlState   state;
  ctrlState   nextState;
  logic [3:0] flags;
  logic       condExReg;
  logic       condEx;
  logic       n, z, c, v;
  logic       nextPC, regW, memW, irW, br, aluOp;
  logic       isAddSub;
  logic       flagWrite;

  assign {n, z, c, v} = flags;
  assign isAddSub  = (bus.Funct[4:1] == 4'b0100) || (bus.Funct[4:1] == 4'b0010);
  assign flagWrite = aluOp & bus.Funct[0] & condExReg;

  // State, flags and the condition result latched at DECODE
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      flags     <= 4'b0000;
      condExReg <= 1'b0;
    end else begin
      state <= nextState;
      if (state == DECODE) condExReg <= condEx;
      if (flagWrite) begin
        flags[3:2] <= bus.ALUFlags[3:2];
        if (isAddSub) flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  // Next state, mux selects and raw enables
  always_comb begin
    nextState     = FETCH;
    nextPC        = 1'b0;
    regW          = 1'b0;
    memW          = 1'b0;
    irW           = 1'b0;
    br            = 1'b0;
    aluOp         = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 2'b00;
    bus.ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        nextState     = DECODE;
        irW           = 1'b1;
        nextPC        = 1'b1;
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        case (bus.Op)
          2'b00:   nextState = bus.Funct[5] ? EXECUTEI : EXECUTER;
          2'b01:   nextState = MEMADR;
          2'b10:   nextState = BRANCH;
          default: nextState = FETCH;
        endcase
      end
      MEMADR: begin
        nextState   = bus.Funct[0] ? MEMREAD : MEMWRITE;
        bus.ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        nextState  = MEMWB;
        bus.AdrSrc = 1'b1;
      end
      MEMWB: begin
        regW          = 1'b1;
        bus.ResultSrc = 2'b01;
      end
      MEMWRITE: begin
        memW       = 1'b1;
        bus.AdrSrc = 1'b1;
      end
      EXECUTER: begin
        nextState = ALUWB;
        aluOp     = 1'b1;
      end
      EXECUTEI: begin
        nextState   = ALUWB;
        aluOp       = 1'b1;
        bus.ALUSrcB = 2'b01;
      end
      ALUWB: regW = 1'b1;
      BRANCH: begin
        br            = 1'b1;
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
      end
      default: nextState = FETCH;
    endcase
  end

  // Condition check against the stored flags
  always_comb begin
    condEx = 1'b0;
    case (bus.Cond)
      4'b0000: condEx = z;
      4'b0001: condEx = ~z;
      4'b0010: condEx = c;
      4'b0011: condEx = ~c;
      4'b0100: condEx = n;
      4'b0101: condEx = ~n;
      4'b0110: condEx = v;
      4'b0111: condEx = ~v;
      4'b1000: condEx = c & ~z;
      4'b1001: condEx = ~c | z;
      4'b1010: condEx = (n == v);
      4'b1011: condEx = (n != v);
      4'b1100: condEx = ~z & (n == v);
      4'b1101: condEx = z | (n != v);
      4'b1110: condEx = 1'b1;
      default: condEx = 1'b0;
    endcase
  end

  always_comb begin
    bus.ALUControl = 2'b00;
    if (aluOp) begin
      case (bus.Funct[4:1])
        4'b0100: bus.ALUControl = 2'b00;
        4'b0010: bus.ALUControl = 2'b01;
        4'b0000: bus.ALUControl = 2'b10;
        4'b1100: bus.ALUControl = 2'b11;
        default: bus.ALUControl = 2'b00;
      endcase
    end
  end

  always_comb begin
    case (bus.Op)
      2'b00:   bus.ImmSrc = 2'b01;
      2'b01:   bus.ImmSrc = 2'b10;
      2'b10:   bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  assign bus.RegSrc = {(bus.Op == 2'b01) & ~bus.Funct[0], bus.Op == 2'b10};

  // Enables are gated by the latched condition and killed during reset
  assign bus.PCWrite  = ~reset & (nextPC | (br & condExReg));
  assign bus.RegWrite = ~reset & regW & condExReg;
  assign bus.MemWrite = ~reset & memW & condExReg;
  assign bus.IRWrite  = ~reset & irW;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: a reference model pushes the
// expected per-cycle state and controls, which are popped at each negedge.
module tb_multicycle_control;

  localparam logic [3:0] sFetch    = 4'd0;
  localparam logic [3:0] sDecode   = 4'd1;
  localparam logic [3:0] sMemAdr   = 4'd2;
  localparam logic [3:0] sMemRead  = 4'd3;
  localparam logic [3:0] sMemWb    = 4'd4;
  localparam logic [3:0] sMemWrite = 4'd5;
  localparam logic [3:0] sExecR    = 4'd6;
  localparam logic [3:0] sExecI    = 4'd7;
  localparam logic [3:0] sAluWb    = 4'd8;
  localparam logic [3:0] sBranch   = 4'd9;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ctl;
  } expT;

  logic clk;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  expT        sbq[$];
  logic [3:0] mFlags;
  int         vecCount;
  int         missCount;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic condOk(input logic [3:0] cond);
    logic n, z, c, v;
    {n, z, c, v} = mFlags;
    case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] expCtl(input logic [3:0] st, input logic [1:0] op,
                                         input logic [5:0] funct, input logic cx);
    logic pcw, memw, regw, irw, adr, srcA;
    logic [1:0] srcB, res, imm, rsrc, aluc;
    {pcw, memw, regw, irw, adr, srcA} = 6'b0;
    srcB = 2'b00; res = 2'b00; aluc = 2'b00;
    imm  = (op == 2'b00) ? 2'b01 : (op == 2'b01) ? 2'b10 : (op == 2'b10) ? 2'b11 : 2'b00;
    rsrc = {(op == 2'b01) && !funct[0], op == 2'b10};
    case (st)
      sFetch:    begin pcw = 1'b1; irw = 1'b1; srcA = 1'b1; srcB = 2'b10; res = 2'b10; end
      sDecode:   begin srcA = 1'b1; srcB = 2'b10; res = 2'b10; end
      sMemAdr:   srcB = 2'b01;
      sMemRead:  adr = 1'b1;
      sMemWrite: begin adr = 1'b1; memw = cx; end
      sMemWb:    begin res = 2'b01; regw = cx; end
      sAluWb:    regw = cx;
      sBranch:   begin srcB = 2'b01; res = 2'b10; pcw = cx; end
      default:   ;
    endcase
    if (st == sExecR || st == sExecI) begin
      if (st == sExecI) srcB = 2'b01;
      case (funct[4:1])
        4'b0010: aluc = 2'b01;
        4'b0000: aluc = 2'b10;
        4'b1100: aluc = 2'b11;
        default: aluc = 2'b00;
      endcase
    end
    return {pcw, memw, regw, irw, adr, srcA, srcB, res, imm, rsrc, aluc};
  endfunction

  function automatic logic [15:0] gotCtl();
    return {bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite, bus.AdrSrc, bus.ALUSrcA,
            bus.ALUSrcB, bus.ResultSrc, bus.ImmSrc, bus.RegSrc, bus.ALUControl};
  endfunction

  // Runs one instruction from FETCH; cutAt>0 stops after that many states
  task automatic runInstr(input logic [3:0] cond, input logic [1:0] op,
                          input logic [5:0] funct, input logic [3:0] af, input int cutAt);
    logic [3:0] sts[$];
    logic       cx;
    expT        e;
    int         n;
    cx = condOk(cond);
    sts.push_back(sFetch);
    sts.push_back(sDecode);
    case (op)
      2'b00: begin sts.push_back(funct[5] ? sExecI : sExecR); sts.push_back(sAluWb); end
      2'b01: begin
        sts.push_back(sMemAdr);
        if (funct[0]) begin sts.push_back(sMemRead); sts.push_back(sMemWb); end
        else sts.push_back(sMemWrite);
      end
      2'b10: sts.push_back(sBranch);
      default: ;
    endcase
    n = (cutAt > 0) ? cutAt : sts.size();
    for (int i = 0; i < n; i++) sbq.push_back('{st: sts[i], ctl: expCtl(sts[i], op, funct, cx)});
    bus.Cond = cond; bus.Op = op; bus.Funct = funct; bus.ALUFlags = af;
    while (sbq.size() > 0) begin
      @(negedge clk);
      e = sbq.pop_front();
      checkVal("state", 32'(dut.state), 32'(e.st));
      checkVal("ctl", 32'(gotCtl()), 32'(e.ctl));
      @(posedge clk);
      #1;
    end
    if (cutAt == 0) begin
      if (op == 2'b00 && funct[0] && cx) begin
        mFlags[3:2] = af[3:2];
        if (funct[4:1] == 4'b0100 || funct[4:1] == 4'b0010) mFlags[1:0] = af[1:0];
      end
      checkVal("flags", 32'(dut.flags), 32'(mFlags));
    end
  endtask

  initial begin
    vecCount = 0; missCount = 0; mFlags = 4'b0000;
    reset = 1'b1;
    bus.Cond = 4'hE; bus.Op = 2'b01; bus.Funct = 6'b011001; bus.ALUFlags = 4'b0000;
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("rstState", 32'(dut.state), 32'(sFetch));
    checkVal("rstWrites", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    checkVal("rstFlags", 32'(dut.flags), 32'(0));

    runInstr(4'hE, 2'b00, 6'b001001, 4'b0100, 0); // ADDS -> Z
    runInstr(4'h0, 2'b00, 6'b000101, 4'b0000, 0); // SUBSEQ clears Z, still writes
    runInstr(4'h0, 2'b10, 6'b000000, 4'b0000, 0); // BEQ not taken
    runInstr(4'hE, 2'b00, 6'b001001, 4'b0111, 0); // ADDS -> Z,C,V
    runInstr(4'h0, 2'b10, 6'b000000, 4'b0000, 0); // BEQ taken
    runInstr(4'hE, 2'b01, 6'b011001, 4'b0000, 0); // LDR
    runInstr(4'hE, 2'b01, 6'b011000, 4'b0000, 0); // STR
    runInstr(4'hE, 2'b00, 6'b111001, 4'b1000, 0); // ORRS imm keeps C,V
    runInstr(4'hA, 2'b00, 6'b000001, 4'b0100, 0); // ANDSGE
    runInstr(4'h1, 2'b00, 6'b001001, 4'b1000, 0); // ADDSNE, fails
    runInstr(4'hF, 2'b00, 6'b001001, 4'b1000, 0); // never
    runInstr(4'hD, 2'b00, 6'b000101, 4'b1010, 0); // SUBSLE
    runInstr(4'h8, 2'b00, 6'b001000, 4'b0000, 0); // ADDHI, no S
    runInstr(4'hE, 2'b11, 6'b000000, 4'b1111, 0); // Op=11 no-op
    runInstr(4'hC, 2'b00, 6'b101000, 4'b0000, 0); // ADDGT imm, fails
    runInstr(4'hE, 2'b00, 6'b000011, 4'b0101, 0); // EORS-like: ALUControl 00, N/Z only
    runInstr(4'hB, 2'b01, 6'b011000, 4'b0000, 0); // STRLT
    runInstr(4'h3, 2'b00, 6'b011001, 4'b0000, 0); // ORRCC

    // Reset in MEMREAD abandons the load
    runInstr(4'hE, 2'b01, 6'b011001, 4'b0000, 3);
    reset = 1'b1;
    @(negedge clk);
    checkVal("midRstState", 32'(dut.state), 32'(sMemRead));
    checkVal("midRstWrites", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'(0));
    @(posedge clk); #1;
    @(negedge clk);
    checkVal("midRstFetch", 32'(dut.state), 32'(sFetch));
    checkVal("midRstFetchWr", 32'({bus.PCWrite, bus.MemWrite, bus.RegWrite, bus.IRWrite}), 32'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    mFlags = 4'b0000;
    checkVal("midRstFlags", 32'(dut.flags), 32'(0));
    runInstr(4'hE, 2'b01, 6'b011001, 4'b0000, 0);
    runInstr(4'hE, 2'b00, 6'b001001, 4'b1100, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 Cond  input  4  instruction bits [31:28], the condition field.
REQ-005 Op  input  2  instruction bits [27:26], the opcode class.
REQ-006 Funct  input  6  instruction bits [25:20]: I, cmd[3:0], S/L.
REQ-007 ALUFlags  input  4  combinational {N,Z,C,V} from the ALU in the current cycle.
REQ-008 PCWrite, MemWrite, RegWrite, IRWrite  output  1 each  write enables.
REQ-009 AdrSrc, ALUSrcA  output  1 each  memory-address mux select and ALU A-operand mux select.
REQ-010 ResultSrc, ALUSrcB, RegSrc, ALUControl  output  2 each  result mux, ALU B mux, register-file read-address muxes, ALU operation.
REQ-011 ImmSrc  output  2  extender mode: 01 data-processing rotate, 10 LDR/STR 12-bit offset, 11 branch 24-bit offset, 00 none.

Function
REQ-012 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB and BRANCH, and every state SHALL last exactly one cycle.
REQ-013 Transitions SHALL be as follows.
- FETCH->DECODE.
- DECODE: Op=00 and Funct[5]=0 -> EXECUTER; Op=00 and Funct[5]=1 -> EXECUTEI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH.
- MEMADR: Funct[0]=1 -> MEMREAD, else -> MEMWRITE.
- MEMREAD->MEMWB.
- EXECUTER and EXECUTEI -> ALUWB.
- MEMWB, MEMWRITE, ALUWB and BRANCH -> FETCH.
REQ-014 Mux selects per state SHALL be, as (AdrSrc, ALUSrcA, ALUSrcB, ResultSrc).
- FETCH: (0, 1, 10, 10).
- DECODE: (x, 1, 10, 10).
- MEMADR, EXECUTEI and BRANCH: ALUSrcA=0, ALUSrcB=01; BRANCH also has ResultSrc=10.
- EXECUTER: ALUSrcA=0, ALUSrcB=00.
- MEMREAD and MEMWRITE: AdrSrc=1, ResultSrc=00.
- MEMWB: ResultSrc=01.
- ALUWB: ResultSrc=00.
- Any select not listed for a state SHALL be driven 0.
REQ-015 Raw enables SHALL be as follows.
- IRWrite=1 and NextPC=1 in FETCH only.
- RegW=1 in MEMWB and ALUWB.
- MemW=1 in MEMWRITE.
- Br=1 in BRANCH.
- ALUOp=1 in EXECUTER and EXECUTEI.
REQ-016 Gated outputs SHALL be: PCWrite = NextPC | (Br & CondExReg); RegWrite = RegW & CondExReg; MemWrite = MemW & CondExReg.
REQ-017 CondEx SHALL be evaluated combinationally from Cond against the stored flags (N,Z,C,V).
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL(1110) 1; 1111 gives 0.
REQ-018 CondExReg SHALL load CondEx at the end of the DECODE cycle and hold that value until the next DECODE, so that flag updates during EXECUTE do not alter gating of the same instruction.
REQ-019 When ALUOp=0, ALUControl SHALL be 00 (add).
REQ-020 When ALUOp=1, ALUControl SHALL decode Funct[4:1] as: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11; any other value SHALL give 00.
REQ-021 Flag writes SHALL occur at the end of an EXECUTER or EXECUTEI cycle only when Funct[0]=1 and CondExReg=1.
- N and Z SHALL load ALUFlags[3:2].
- C and V SHALL load ALUFlags[1:0] only for ADD or SUB.
REQ-022 ImmSrc SHALL be a combinational function of Op: 00->01, 01->10, 10->11, 11->00.
REQ-023 RegSrc[0] SHALL be 1 iff Op=10; RegSrc[1] SHALL be 1 iff Op=01 and Funct[0]=0 (STR).
REQ-024 Op=11 SHALL produce no register, memory, flag or PC write beyond the FETCH cycle.

Reset
REQ-025 While reset=1 at a rising edge, the FSM SHALL load FETCH, and the flags and CondExReg SHALL load 0.
REQ-026 While reset=1, PCWrite, MemWrite, RegWrite and IRWrite SHALL be forced to 0 combinationally.
REQ-027 Reset asserted mid-instruction SHALL abandon the instruction with no further writes; the first cycle after reset deasserts SHALL be FETCH.

Verification
REQ-028 ADD register instruction (Cond=1110, Op=00, Funct=001001), ALUFlags=0100.
- States SHALL be FETCH, DECODE, EXECUTER, ALUWB, then FETCH.
- RegWrite=1 in cycle 4 only.
- Z=1 and N=0 after cycle 3.
REQ-029 LDR (Op=01, Funct[0]=1).
- States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB.
- ImmSrc=10 throughout; AdrSrc=1 in MEMREAD; ResultSrc=01 and RegWrite=1 in MEMWB.
REQ-030 STR (Op=01, Funct=011000).
- RegSrc=10.
- MemWrite=1 in MEMWRITE only; RegWrite=0 throughout.
REQ-031 BEQ (Cond=0000, Op=10).
- With Z=1: PCWrite=1 in BRANCH, ImmSrc=11, RegSrc=01.
- With Z=0: PCWrite=0 in BRANCH; 3 cycles in both cases.
REQ-032 SUBS with Cond=EQ, flags Z=1 at DECODE, ALUFlags=0000 in EXECUTE.
- Z SHALL clear after EXECUTE.
- RegWrite SHALL still be 1 in ALUWB, because CondExReg was latched in DECODE.
REQ-033 Reset asserted in MEMREAD.
- Writes SHALL be 0 during reset.
- FETCH SHALL be the first state after reset deasserts.
- Flags SHALL read 0000.
